// File: rtl/top_stim_chk.sv
// rtl/top_stim_chk.sv - LFSR stimulus generator and shift-add self-checker for the Y = A*B + C*D datapath
module top_stim_chk #(
    parameter int          PERIOD  = 100,
    parameter logic [31:0] SEED    = 32'h0000_0001,
    parameter int          NUM_VEC = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic [7:0]  a_out,
    output logic [7:0]  b_out,
    output logic [7:0]  c_out,
    output logic [7:0]  d_out,
    input  logic [17:0] y_in,
    output logic        busy,
    output logic        done,
    output logic        mismatch,
    output logic [15:0] vec_cnt,
    output logic [15:0] err_cnt
);
    typedef enum logic [2:0] {IDLE, GEN, MUL, WAIT, CHECK} state_t;

    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [15:0] LAST_WAIT = 16'(PERIOD - 2);
    localparam logic [15:0] NUM_VEC_C = 16'(NUM_VEC);
    localparam bit          RUN_LIMIT = (NUM_VEC != 0);

    state_t      state, state_nxt;
    logic [31:0] lfsr, lfsr_step;
    logic [15:0] win_cnt;
    logic [17:0] acc;
    logic [17:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] vec_cnt_inc;
    logic        run_end;

    always_comb begin
        lfsr_step   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
        vec_cnt_inc = vec_cnt + 16'd1;
        run_end     = RUN_LIMIT && (vec_cnt_inc == NUM_VEC_C);
        busy        = (state != IDLE);
        mismatch    = (state == CHECK) && (y_in != acc);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = GEN;
            GEN:     state_nxt = MUL;
            MUL:     if (win_cnt == 16'd16) state_nxt = WAIT;
            // leave one cycle early so CHECK lands on window cycle PERIOD-1
            WAIT:    if (win_cnt == LAST_WAIT) state_nxt = CHECK;
            CHECK:   state_nxt = run_end ? IDLE : GEN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            lfsr    <= SEED_EFF;
            a_out   <= 8'h0;
            b_out   <= 8'h0;
            c_out   <= 8'h0;
            d_out   <= 8'h0;
            done    <= 1'b0;
            vec_cnt <= 16'h0;
            err_cnt <= 16'h0;
            win_cnt <= 16'h0;
            acc     <= 18'h0;
            mcand   <= 18'h0;
            mplier  <= 8'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        done    <= 1'b0;
                        vec_cnt <= 16'h0;
                        err_cnt <= 16'h0;
                    end
                end
                GEN: begin
                    // win_cnt holds the index of the current window cycle
                    lfsr                         <= lfsr_step;
                    {d_out, c_out, b_out, a_out} <= lfsr_step;
                    win_cnt                      <= 16'd1;
                    acc                          <= 18'h0;
                    mcand                        <= {10'h0, lfsr_step[7:0]};
                    mplier                       <= lfsr_step[15:8];
                end
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    if (win_cnt == 16'd8) begin
                        mcand  <= {10'h0, c_out};
                        mplier <= d_out;
                    end else begin
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                    win_cnt <= win_cnt + 16'd1;
                end
                WAIT: win_cnt <= win_cnt + 16'd1;
                CHECK: begin
                    vec_cnt <= vec_cnt_inc;
                    if (mismatch && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
                    if (run_end) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_top_stim_chk.sv
// tb/tb_top_stim_chk.sv - self-checking bench for top_stim_chk against an LFSR/arithmetic reference model
module tb_top_stim_chk;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start0, start1, start2, start3;
    logic [7:0]  a0, b0, c0, d0, a1, b1, c1, d1, a2, b2, c2, d2, a3, b3, c3, d3, a4, b4, c4, d4;
    logic [17:0] y0, y1, y2, y3, y4;
    logic [17:0] delta0, delta1, delta2, delta3;
    logic        busy0, busy1, busy2, busy3, busy4;
    logic        done0, done1, done2, done3, done4;
    logic        mis0, mis1, mis2, mis3, mis4;
    logic [15:0] vc0, vc1, vc2, vc3, vc4, ec0, ec1, ec2, ec3, ec4;

    // TOP datapath model with optional error injection
    assign y0 = (18'(a0) * 18'(b0) + 18'(c0) * 18'(d0)) ^ delta0;
    assign y1 = (18'(a1) * 18'(b1) + 18'(c1) * 18'(d1)) ^ delta1;
    assign y2 = (18'(a2) * 18'(b2) + 18'(c2) * 18'(d2)) ^ delta2;
    assign y3 = (18'(a3) * 18'(b3) + 18'(c3) * 18'(d3)) ^ delta3;
    assign y4 = 18'(a4) * 18'(b4) + 18'(c4) * 18'(d4);

    top_stim_chk #(.PERIOD(100), .SEED(32'h0000_0001), .NUM_VEC(0)) u0 (
        .sys_clk(clk), .sys_rst(rst), .start(start0), .a_out(a0), .b_out(b0), .c_out(c0), .d_out(d0),
        .y_in(y0), .busy(busy0), .done(done0), .mismatch(mis0), .vec_cnt(vc0), .err_cnt(ec0));
    top_stim_chk #(.PERIOD(100), .SEED(32'h0001_FE02), .NUM_VEC(1)) u1 (
        .sys_clk(clk), .sys_rst(rst), .start(start1), .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1),
        .y_in(y1), .busy(busy1), .done(done1), .mismatch(mis1), .vec_cnt(vc1), .err_cnt(ec1));
    top_stim_chk #(.PERIOD(20), .SEED(32'hFFBF_FFF9), .NUM_VEC(1)) u2 (
        .sys_clk(clk), .sys_rst(rst), .start(start2), .a_out(a2), .b_out(b2), .c_out(c2), .d_out(d2),
        .y_in(y2), .busy(busy2), .done(done2), .mismatch(mis2), .vec_cnt(vc2), .err_cnt(ec2));
    top_stim_chk #(.PERIOD(20), .SEED(32'h0000_0001), .NUM_VEC(3)) u3 (
        .sys_clk(clk), .sys_rst(rst), .start(start3), .a_out(a3), .b_out(b3), .c_out(c3), .d_out(d3),
        .y_in(y3), .busy(busy3), .done(done3), .mismatch(mis3), .vec_cnt(vc3), .err_cnt(ec3));
    top_stim_chk #(.PERIOD(20), .SEED(32'h0000_0000), .NUM_VEC(1)) u4 (
        .sys_clk(clk), .sys_rst(rst), .start(start2), .a_out(a4), .b_out(b4), .c_out(c4), .d_out(d4),
        .y_in(y4), .busy(busy4), .done(done4), .mismatch(mis4), .vec_cnt(vc4), .err_cnt(ec4));

    typedef struct {
        logic [17:0] delta;
        logic [7:0]  a, b, c, d;
        logic        mis;
        logic [15:0] ecnt;
    } vec_t;

    localparam int NV = 6;
    vec_t tbl[NV];
    int n_cmp = 0;
    int n_fail = 0;

    function automatic logic [31:0] lfsr_model(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        logic [15:0] errs;
        logic [31:0] prev, cur;

        rst = 1'b1;
        {start0, start1, start2, start3} = '0;
        {delta0, delta1, delta2, delta3} = '0;
        tick(2);
        chk("rst_abcd", {a0, b0, c0, d0}, 32'h0);
        chk("rst_flags", {busy0, done0, mis0}, 3'b000);
        chk("rst_cnts", {vc0, ec0}, 32'h0);
        rst = 1'b0;

        q = 32'h1;
        errs = 16'h0;
        for (int i = 0; i < NV; i++) begin
            q = lfsr_model(q);
            {tbl[i].d, tbl[i].c, tbl[i].b, tbl[i].a} = q;
            if (i == 0) tbl[i].delta = 18'h0;
            else if (i == 1 || $urandom_range(0, 2) == 0) tbl[i].delta = 18'($urandom_range(1, 18'h3FFFF));
            else tbl[i].delta = 18'h0;
            tbl[i].mis = (tbl[i].delta != 18'h0);
            if (tbl[i].mis) errs = errs + 16'd1;
            tbl[i].ecnt = errs;
        end

        // free-running run, randomized error injection
        start0 = 1'b1; tick(1); start0 = 1'b0;
        chk("busy_after_start", busy0, 1'b1);
        for (int i = 0; i < NV; i++) begin
            delta0 = tbl[i].delta;
            tick(1);
            chk("vec_abcd", {a0, b0, c0, d0}, {tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d});
            tick(98);
            chk("vec_mis", mis0, tbl[i].mis);
            if (i == 0) chk("vec0_y", y0, 32'd4096);
            tick(1);
            chk("vec_mis_end", mis0, 1'b0);
            chk("vec_cnt", vc0, i + 1);
            chk("err_cnt", ec0, tbl[i].ecnt);
        end

        // reset at cycle 40 of a window
        tick(40);
        pulse_rst();
        chk("midrst_abcd", {a0, b0, c0, d0}, 32'h0);
        chk("midrst_flags", {busy0, done0, mis0}, 3'b000);
        chk("midrst_cnts", {vc0, ec0}, 32'h0);
        start0 = 1'b1; tick(1); start0 = 1'b0;
        delta0 = 18'h0;
        tick(1);
        chk("restart_abcd", {a0, b0, c0, d0}, 32'h0300_2080);
        tick(98);
        chk("restart_mis", mis0, 1'b0);
        chk("restart_y", y0, 32'd4096);
        tick(1);
        chk("restart_cnts", {vc0, ec0}, {16'd1, 16'd0});
        pulse_rst();

        // single mismatch: expected 255, TOP returns 254
        delta1 = 18'h1;
        start1 = 1'b1; tick(1); start1 = 1'b0;
        tick(1);
        chk("mis_abcd", {a1, b1, c1, d1}, 32'h01FF_0000);
        tick(97);
        chk("mis_c98", mis1, 1'b0);
        tick(1);
        chk("mis_c99", mis1, 1'b1);
        chk("mis_y", y1, 32'd254);
        tick(1);
        chk("mis_c100", mis1, 1'b0);
        chk("mis_err", ec1, 16'd1);
        chk("mis_vec", vc1, 16'd1);
        chk("mis_done_busy", {done1, busy1}, 2'b10);
        pulse_rst();

        // max arithmetic; zero seed instance shares this start
        start2 = 1'b1; tick(1); start2 = 1'b0;
        tick(1);
        chk("max_abcd", {a2, b2, c2, d2}, 32'hFFFF_FFFF);
        chk("seed0_abcd", {a4, b4, c4, d4}, 32'h0300_2080);
        tick(18);
        chk("max_pass_mis", mis2, 1'b0);
        chk("max_pass_y", y2, 32'd130050);
        tick(1);
        chk("max_pass_err", ec2, 16'd0);
        chk("max_pass_done", {done2, vc2}, {1'b1, 16'd1});
        chk("seed0_done", {done4, ec4}, {1'b1, 16'd0});
        pulse_rst();
        delta2 = 18'h20000;
        start2 = 1'b1; tick(1); start2 = 1'b0;
        tick(19);
        chk("max_fail_mis", mis2, 1'b1);
        chk("max_fail_y", y2, 32'h3FC02);
        tick(1);
        chk("max_fail_err", ec2, 16'd1);
        pulse_rst();

        // run length, window timing, start ignored while busy
        prev = {a3, b3, c3, d3};
        start3 = 1'b1; tick(1); start3 = 1'b0;
        for (int cyc = 0; cyc <= 65; cyc++) begin
            if (cyc > 0) tick(1);
            start3 = (cyc == 30);
            cur = {a3, b3, c3, d3};
            chk("run_change", cur != prev, (cyc == 1) || (cyc == 21) || (cyc == 41));
            prev = cur;
            chk("run_busy", busy3, cyc < 60);
            chk("run_done", done3, cyc >= 60);
        end
        start3 = 1'b0;
        chk("run_cnts", {vc3, ec3}, {16'd3, 16'd0});
        pulse_rst();

        // error counter saturation
        delta3 = 18'h1;
        start3 = 1'b1; tick(1); start3 = 1'b0;
        tick(10);
        force u3.err_cnt = 16'hFFFF;
        tick(1);
        release u3.err_cnt;
        tick(8);
        chk("sat_mis", mis3, 1'b1);
        tick(1);
        chk("sat_err", ec3, 16'hFFFF);
        chk("sat_vec", vc3, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
